stopwatch_control: RTL
======================

# stopwatch_control

Front-end controller for the stopwatch timer. Debounces the raw start/stop, lap and reset buttons, runs the run/pause/lap state machine, and divides the system clock into a one-cycle `enable_Count` tick (default 100 Hz, hundredths of a second). That tick, and the `clear_Count` pulse, drive the enable and clear inputs of the first BCD counter digit of the cascade. `display_Hold` tells the display stage to freeze the shown time while counting continues.

## Interface
- `CLOCK_HZ`, 50_000_000, system clock frequency.
- `TICK_HZ`, 100, `enable_Count` rate. `DIV = CLOCK_HZ/TICK_HZ` must be an integer ≥ 2.
- `DEBOUNCE_CYCLES`, 500_000, consecutive identical synchronized samples (≥ 1) required to accept a new button level.
- `clock`  in  1  system clock; all logic on the rising edge.
- `clear`  in  1  reset; synchronous and active-high.
- `start_Stop_Button`  in  1  raw asynchronous button, high = pressed.
- `lap_Button`  in  1  raw asynchronous button, high = pressed.
- `reset_Button`  in  1  raw asynchronous button, high = pressed.
- `enable_Count`  out  1  registered one-cycle tick to the BCD counter chain.
- `clear_Count`  out  1  registered one-cycle pulse that zeroes the BCD counter chain.
- `running`  out  1  high in RUNNING or LAP.
- `display_Hold`  out  1  high in LAP.

## Operation
- **Input conditioning**
  - Each button passes through a 2-flop synchronizer.
  - A per-button debounce counter accepts a new level after `DEBOUNCE_CYCLES` consecutive equal samples. Any differing sample restarts the count.
  - A rising edge of the accepted level gives a one-cycle press event. Release produces no event.
- **States:** IDLE, RUNNING, PAUSED, LAP.
- **IDLE**
  - start → RUNNING; prescaler set to 0.
  - reset → stay IDLE; pulse `clear_Count`.
  - lap ignored.
- **RUNNING**
  - start → PAUSED.
  - lap → LAP.
  - reset ignored.
- **LAP** (counting continues, display frozen)
  - lap → RUNNING.
  - start → PAUSED; hold released.
  - reset ignored.
- **PAUSED**
  - start → RUNNING; prescaler resumes from its held value.
  - reset → IDLE; pulse `clear_Count`; prescaler set to 0.
  - lap ignored.
- **Simultaneous events in the same cycle**, priority reset > start > lap:
  - Reset is only effective in IDLE or PAUSED. Where it is ignored, start is evaluated next, then lap.
  - Example: PAUSED with reset + start → IDLE with clear. RUNNING with reset + start → PAUSED.
- **Prescaler**
  - Width `$clog2(DIV)`.
  - Increments every cycle in RUNNING/LAP and holds in IDLE/PAUSED.
  - At `DIV-1` it wraps to 0 and schedules `enable_Count` for the next cycle.
- **Invariant:** `enable_Count` and `clear_Count` are never high in the same cycle.

## Timing
- **Reset:** while `clear` is high on an edge:
  - state IDLE;
  - prescaler, debounce counters and synchronizers zeroed;
  - accepted levels 0;
  - all four outputs 0.
- **Press latency:** a raw level held from cycle 0 produces its event in cycle `2 + DEBOUNCE_CYCLES`. The state and `running`/`display_Hold` change at the next edge.
- **`clear_Count` timing:** high for exactly one cycle, the cycle after the reset event.
- **Tick cadence:** from entry into RUNNING, the first `enable_Count` comes `DIV` cycles later, then exactly every `DIV` cycles while RUNNING/LAP. Each tick is exactly 1 cycle wide.
- **RUNNING ↔ LAP:** the prescaler is not disturbed; cadence is unbroken.
- **Pause at the boundary:** if a pause event coincides with prescaler = `DIV-1`:
  - no tick is emitted and the prescaler holds at `DIV-1`;
  - the tick is emitted in the first cycle after resume.
- **Accuracy:** total ticks equal total RUNNING/LAP cycles divided by `DIV`, with no loss across pauses.
- **Reset mid-operation:** `clear` in any state aborts it immediately. No tick or clear pulse is emitted on the following cycle.

## Test plan
Bench parameters: `CLOCK_HZ=1000`, `TICK_HZ=100` (`DIV=10`), `DEBOUNCE_CYCLES=4`.

- **Debounce:** start button bouncing 1-0-1 at 1-cycle intervals, then held 10 cycles.
  - Expect exactly one start event, in cycle 6 after the final rise.
  - `running` = 1 from the next cycle.
- **Tick cadence:** start from IDLE, run 100 cycles.
  - Expect exactly 10 `enable_Count` pulses, spaced 10 cycles apart, each 1 cycle wide, the first 10 cycles after entering RUNNING.
- **Pause/resume at boundary:** pause when prescaler = 9, hold PAUSED 50 cycles, then resume.
  - No tick while paused.
  - Tick in the first cycle after re-entering RUNNING.
  - Tick total over the full run = RUNNING cycles / 10.
- **Lap:** lap in RUNNING, then lap again 30 cycles later.
  - `display_Hold` = 1 for the interval.
  - Ticks continue uninterrupted.
  - Start while in LAP → PAUSED with `display_Hold` = 0.
- **Reset priority:**
  - In PAUSED, reset + start in the same cycle → IDLE with a single 1-cycle `clear_Count`.
  - In RUNNING, the same stimulus → PAUSED with no `clear_Count`.
- **Synchronous reset:** assert `clear` for 1 cycle mid-RUNNING at prescaler = 5.
  - Next cycle: all outputs 0, state IDLE.
  - A new start gives its first tick 10 cycles after entering RUNNING.

Source files
------------

// File: rtl/stopwatch_control.sv
// stopwatch_control
//   Front end of the stopwatch timer. Conditions the three raw buttons
//   (2-flop synchronizer, debounce, press detection), sequences the
//   IDLE / RUNNING / PAUSED / LAP state machine, and divides the system
//   clock into the one-cycle enable_Count tick for the BCD counter chain.
//
//   Parameters
//     CLOCK_HZ         system clock frequency
//     TICK_HZ          enable_Count rate; CLOCK_HZ/TICK_HZ must be an integer >= 2
//     DEBOUNCE_CYCLES  consecutive equal samples needed to accept a new level (>= 1)
//
//   Ports
//     clock              system clock, rising edge
//     clear              synchronous active-high reset
//     start_Stop_Button  raw button, high = pressed
//     lap_Button         raw button, high = pressed
//     reset_Button       raw button, high = pressed
//     enable_Count       registered one-cycle count tick
//     clear_Count        registered one-cycle counter clear pulse
//     running            high in RUNNING or LAP
//     display_Hold       high in LAP (display frozen, counting continues)
//     fsm_state          current state: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 LAP
module stopwatch_control #(
   parameter int CLOCK_HZ        = 50_000_000,
   parameter int TICK_HZ         = 100,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       start_Stop_Button,
   input  logic       lap_Button,
   input  logic       reset_Button,
   output logic       enable_Count,
   output logic       clear_Count,
   output logic       running,
   output logic       display_Hold,
   output logic [1:0] fsm_state
);

   localparam int DIV = CLOCK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      LAP     = 2'd3
   } state_t;

   state_t        state;

   // Button vectors are ordered {reset, lap, start}.
   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    level;
   logic [2:0]    level_q;
   logic [2:0]    press;
   logic [DW-1:0] db_cnt [3];

   logic [PW-1:0] presc;
   logic [PW-1:0] presc_step;
   logic          presc_wrap;
   logic          start_ev;
   logic          lap_ev;
   logic          reset_ev;

   assign raw = {reset_Button, lap_Button, start_Stop_Button};

   // The debounce counter runs only while the synchronized sample differs
   // from the accepted level; any sample equal to the accepted level
   // restarts it, so acceptance needs DEBOUNCE_CYCLES differing samples in a row.
   always_ff @(posedge clock) begin
      if (clear) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_q <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DEB_LAST) begin
               level[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // One-cycle press events on the rising edge of the accepted level.
   assign press    = level & ~level_q;
   assign start_ev = press[0];
   assign lap_ev   = press[1];
   assign reset_ev = press[2];

   assign presc_wrap = (presc == PRESC_LAST);
   assign presc_step = presc_wrap ? '0 : presc + 1'b1;

   // The prescaler advances on every edge whose next state counts
   // (RUNNING/LAP), except the entry from IDLE which restarts it at 0.
   // A pause edge therefore holds the prescaler, and a resume edge
   // advances it: a pause that lands on DIV-1 defers that tick to the
   // first cycle after resume, so no count is lost across a pause.
   always_ff @(posedge clock) begin
      if (clear) begin
         state        <= IDLE;
         presc        <= '0;
         enable_Count <= 1'b0;
         clear_Count  <= 1'b0;
         running      <= 1'b0;
         display_Hold <= 1'b0;
      end else begin
         enable_Count <= 1'b0;
         clear_Count  <= 1'b0;
         case (state)
            IDLE: begin
               if (reset_ev) begin
                  clear_Count <= 1'b1;
               end else if (start_ev) begin
                  state   <= RUNNING;
                  presc   <= '0;
                  running <= 1'b1;
               end
            end
            RUNNING: begin
               if (start_ev) begin
                  state   <= PAUSED;
                  running <= 1'b0;
               end else begin
                  if (lap_ev) begin
                     state        <= LAP;
                     display_Hold <= 1'b1;
                  end
                  presc        <= presc_step;
                  enable_Count <= presc_wrap;
               end
            end
            LAP: begin
               if (start_ev) begin
                  state        <= PAUSED;
                  running      <= 1'b0;
                  display_Hold <= 1'b0;
               end else begin
                  if (lap_ev) begin
                     state        <= RUNNING;
                     display_Hold <= 1'b0;
                  end
                  presc        <= presc_step;
                  enable_Count <= presc_wrap;
               end
            end
            PAUSED: begin
               if (reset_ev) begin
                  state       <= IDLE;
                  clear_Count <= 1'b1;
                  presc       <= '0;
               end else if (start_ev) begin
                  state        <= RUNNING;
                  running      <= 1'b1;
                  presc        <= presc_step;
                  enable_Count <= presc_wrap;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule
